// File: rtl/dmem_responder.sv
// dmem_responder: data-memory target for the core's load/store port.
// One request at a time is accepted over req_valid/req_ready, sized by
// RISC-V funct3 (byte/half/word, signed/unsigned loads), and answered
// LATENCY+1 edges later over rsp_valid/rsp_ready with data or an error.
//
// Optional feature macro: DMEM_MMIO_LED_EN adds a 6-bit LED register at
// LED_ADDR and the leds output port.
//
// Ports:
//   clk        clock, all state updates on posedge
//   rst        asynchronous active-low reset
//   req_valid  request present            req_ready  responder can accept
//   req_wen    1=store, 0=load            req_addr   byte address
//   req_wdata  store data                 req_fn3    funct3 size/sign code
//   rsp_valid  response present           rsp_ready  initiator takes response
//   rsp_rdata  load result (0 for stores/errors)
//   rsp_err    misaligned, out-of-range or illegal funct3
//   leds       MMIO LED register (DMEM_MMIO_LED_EN only)
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] LED_ADDR    = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_fn3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
`ifdef DMEM_MMIO_LED_EN
  ,
  output logic [5:0]  leds
`endif
);

  localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W     = 4;
  localparam logic [31:0] MEM_BYTES = 32'(4 * DEPTH_WORDS);
`ifdef DMEM_MMIO_LED_EN
  localparam bit          LED_EN    = 1'b1;
`else
  localparam bit          LED_EN    = 1'b0;
`endif

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [31:0] mem [DEPTH_WORDS];

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cap;
  logic             wen_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [2:0]       fn3_q;
  logic [31:0]      rsp_rdata_d;
  logic             rsp_err_d;
  logic             mem_we;
  logic [5:0]       led_val;
`ifdef DMEM_MMIO_LED_EN
  logic [5:0]       led_d;
  assign led_val = leds;
`else
  assign led_val = 6'd0;
`endif

  // Access decode on the captured request
  logic [31:0]      off;
  logic             in_rng;
  logic             is_led;
  logic [IDX_W-1:0] idx;
  logic [31:0]      rword;
  logic [1:0]       size;
  logic             misalign;
  logic             fn_bad;
  logic             acc_err;
  logic [7:0]       sel_b;
  logic [15:0]      sel_h;
  logic [31:0]      load_data;
  logic [3:0]       lane_m;
  logic [31:0]      wrep;
  logic [31:0]      bit_m;
  logic [31:0]      wr_word;

  always_comb begin
    off      = addr_q - BASE_ADDR;
    in_rng   = off < MEM_BYTES;
    is_led   = LED_EN && (addr_q == LED_ADDR);
    idx      = IDX_W'(off >> 2);
    rword    = is_led ? {26'd0, led_val} : mem[idx];
    size     = fn3_q[1:0];
    misalign = ((size == 2'b01) && addr_q[0]) ||
               ((size == 2'b10) && (addr_q[1:0] != 2'b00));
    if (wen_q) fn_bad = fn3_q[2] || (size == 2'b11);
    else       fn_bad = (fn3_q == 3'b011) || (fn3_q == 3'b110) || (fn3_q == 3'b111);
    acc_err  = misalign || fn_bad || !(in_rng || is_led);

    case (addr_q[1:0])
      2'd0:    sel_b = rword[7:0];
      2'd1:    sel_b = rword[15:8];
      2'd2:    sel_b = rword[23:16];
      default: sel_b = rword[31:24];
    endcase
    sel_h = addr_q[1] ? rword[31:16] : rword[15:0];

    case (fn3_q)
      3'b000:  load_data = {{24{sel_b[7]}}, sel_b};
      3'b100:  load_data = {24'd0, sel_b};
      3'b001:  load_data = {{16{sel_h[15]}}, sel_h};
      3'b101:  load_data = {16'd0, sel_h};
      3'b010:  load_data = rword;
      default: load_data = 32'd0;
    endcase

    // Stores replicate the low data into every lane and merge by lane mask
    case (size)
      2'b00: begin
        lane_m = 4'b0001 << addr_q[1:0];
        wrep   = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        lane_m = addr_q[1] ? 4'b1100 : 4'b0011;
        wrep   = {2{wdata_q[15:0]}};
      end
      default: begin
        lane_m = 4'b1111;
        wrep   = wdata_q;
      end
    endcase
    bit_m   = {{8{lane_m[3]}}, {8{lane_m[2]}}, {8{lane_m[1]}}, {8{lane_m[0]}}};
    wr_word = (rword & ~bit_m) | (wrep & bit_m);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cap         = 1'b0;
    mem_we      = 1'b0;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
`ifdef DMEM_MMIO_LED_EN
    led_d       = leds;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          cap     = 1'b1;
          cnt_d   = CNT_W'(LATENCY);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d     = S_RESP;
          rsp_err_d   = acc_err;
          rsp_rdata_d = (acc_err || wen_q) ? 32'd0 : load_data;
          mem_we      = wen_q && !acc_err && !is_led;
`ifdef DMEM_MMIO_LED_EN
          if (wen_q && !acc_err && is_led) led_d = wdata_q[5:0];
`endif
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_rdata_d = 32'd0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, capture and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wen_q     <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      fn3_q     <= 3'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
`ifdef DMEM_MMIO_LED_EN
      leds      <= 6'd0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      if (cap) begin
        wen_q   <= req_wen;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        fn3_q   <= req_fn3;
      end
      req_ready <= (state_d == S_IDLE);
      rsp_valid <= (state_d == S_RESP);
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
`ifdef DMEM_MMIO_LED_EN
      leds      <= led_d;
`endif
    end
  end

  // Storage is never reset; writes happen only on the WAIT-exit edge
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= wr_word;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder (target side) for the core's load/store port.
- Accepts one request at a time over a valid/ready handshake and applies RISC-V fn3 sizing (byte/half/word, signed/unsigned loads).
- Returns read data or an error after a programmable latency, over a second valid/ready handshake.
- Replaces the zero-latency simulation data memory when the core moves to a handshaked memory interface.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit storage words (power of two).
- BASE_ADDR, 32'h8000_0000, byte address of word 0; valid range is BASE_ADDR to BASE_ADDR+4*DEPTH_WORDS-1.
- LATENCY, 2, extra wait cycles between acceptance and response (0..15).
- LED_ADDR, 32'h1000_0000, MMIO LED register address (used only with DMEM_MMIO_LED_EN).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_wen  in  1  1=store, 0=load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low byte/half used for SB/SH.
- req_fn3  in  3  RISC-V funct3 size/sign code.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  initiator takes response.
- rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
- rsp_err  out  1  misaligned, out-of-range or illegal fn3.
- leds  out  6  MMIO LED register; port exists only with DMEM_MMIO_LED_EN.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, leds=0.
  - Storage contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid=1: capture wen/addr/wdata/fn3, load the counter with LATENCY, go to WAIT.
- WAIT:
  - req_ready=0.
  - Counter>0: decrement.
  - Counter==0: on that edge perform the access, register rdata/err, go to RESP.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready=1 on an edge, then go to IDLE.
  - req_ready stays 0 in RESP; a new request is accepted no earlier than the cycle after the response handshake.
- Latency: an acceptance at edge k raises rsp_valid after edge k+1+LATENCY.
- Access decoding:
  - Word index = (addr-BASE_ADDR)>>2.
  - Loads: fn3 000 LB sign-extends, 100 LBU zero-extends; the byte is selected by addr[1:0].
  - Loads: fn3 001 LH / 101 LHU select the halfword by addr[1]; 010 LW.
  - Stores: fn3 000 SB, 001 SH, 010 SW write only the selected byte lanes.
- Errors: rsp_err=1, rsp_rdata=0, storage unchanged, when any of:
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - Address outside the valid range.
  - Load fn3 in {011,110,111}.
  - Store fn3 not in {000,001,010}.
- Stores: rsp_rdata=0, rsp_err=0 on success. The write commits on the WAIT-exit edge only.
- Request inputs are ignored outside IDLE; changes to them after acceptance have no effect.
- Reset during WAIT: a pending store is dropped and never committed. Reset during RESP: the response is discarded.
- Back-to-back: a load issued right after a store to the same address returns the stored data.

Optional Feature:
- Macro DMEM_MMIO_LED_EN.
- Defined:
  - A store of any legal size to LED_ADDR writes wdata[5:0] into the leds register (byte lane 0).
  - A load from LED_ADDR returns {26'b0, leds}.
  - Neither touches storage; latency is unchanged.
- Undefined: no leds port; LED_ADDR is an ordinary address, out of range by default, so it responds with rsp_err=1.

Test Plan:
- Reset mid-WAIT: issue SW 0xDEADBEEF to 0x8000_0010 (LATENCY=2), pull rst low one cycle after acceptance. Then LW 0x8000_0010 -> returns prior contents (not 0xDEADBEEF); rsp_valid low during reset.
- SW 0x1234_5678 to 0x8000_0000, then LW same address. Response appears exactly 3 edges after acceptance; rdata 0x1234_5678, err 0.
- Extension: after SW 0x80FF_7F01 to 0x8000_0004:
  - LB 0x8000_0007 -> 0xFFFF_FF80.
  - LBU 0x8000_0007 -> 0x0000_0080.
  - LH 0x8000_0006 -> 0xFFFF_80FF.
  - LHU 0x8000_0004 -> 0x0000_7F01.
- Errors, each -> err=1, rdata=0, memory unchanged:
  - LW 0x8000_0002.
  - SH 0x8000_0001.
  - LW 0x8000_1000.
  - LW with fn3=011.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid, rdata and err stable, req_ready=0 throughout. Release -> IDLE next cycle, req_ready=1.
- DMEM_MMIO_LED_EN defined: SB 0x3F to LED_ADDR -> leds=6'h3F, then LW LED_ADDR -> 0x0000_003F. Macro undefined: same SB -> err=1.
